// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

   localparam int REG_W = 5;
   localparam logic [1:0] JUMP_NONE = 2'b00;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// Combinational load-use detector: the ID instruction reads the register a load in EX is about to write.
module hazard_cmp #(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] ID_Rs,
   input  logic [REG_W-1:0] ID_Rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic             EX_MemRead,
   input  logic [REG_W-1:0] EX_RegDstData,
   output logic             load_use
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = ID_UsesRs && (ID_Rs == EX_RegDstData);
   assign rt_hit = ID_UsesRt && (ID_Rt == EX_RegDstData);

   // Register 0 is hardwired, so a load targeting it never produces a hazard.
   assign load_use = EX_MemRead && (EX_RegDstData != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hold/bubble/flush control for the four pipeline registers and the PC.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall/mult-div/flush event counters.
module pipeline_hazard_ctrl #(
   parameter int REG_W         = pipeline_pkg::REG_W,
   parameter int MULDIV_CYCLES = 4,
   parameter int CNT_W         = 3
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [REG_W-1:0]     ID_Rs,
   input  logic [REG_W-1:0]     ID_Rt,
   input  logic                 ID_UsesRs,
   input  logic                 ID_UsesRt,
   input  logic                 EX_MemRead,
   input  logic [REG_W-1:0]     EX_RegDstData,
   input  logic                 EX_MulDiv,
   input  logic                 MEM_Branch,
   input  logic                 MEM_Zero,
   input  logic [1:0]           MEM_Jump,
   output logic                 PC_Ld,
   output logic                 PCSrc_Redirect,
   output logic                 IFID_Ld,
   output logic                 IFID_Clr,
   output logic                 IDEX_Ld,
   output logic                 IDEX_Clr,
   output logic                 EXMEM_Ld,
   output logic                 EXMEM_Clr,
   output logic                 MEMWB_Ld,
   output logic                 MEMWB_Clr,
   output logic                 MulDiv_Busy,
`ifdef PIPE_PERF_CNT_EN
   output logic [31:0]          Stall_Cnt,
   output logic [31:0]          MulDiv_Cnt,
   output logic [31:0]          Flush_Cnt,
`endif
   output pipeline_pkg::state_t Dbg_State
);

   import pipeline_pkg::*;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             load_use;
   logic             redirect;
   logic             md_entry;
   logic             md_hold;
   logic             stall;

   hazard_cmp #(.REG_W(REG_W)) u_hazard_cmp (
      .ID_Rs         (ID_Rs),
      .ID_Rt         (ID_Rt),
      .ID_UsesRs     (ID_UsesRs),
      .ID_UsesRt     (ID_UsesRt),
      .EX_MemRead    (EX_MemRead),
      .EX_RegDstData (EX_RegDstData),
      .load_use      (load_use)
   );

   assign redirect = (MEM_Branch && MEM_Zero) || (MEM_Jump != JUMP_NONE);
   assign md_entry = (state == RUN) && EX_MulDiv && !redirect;
   // The entry cycle is occupancy cycle 1; counter zero in MD_BUSY is the release cycle.
   assign md_hold  = !redirect && (md_entry || ((state == MD_BUSY) && (cnt != '0)));
   assign stall    = !redirect && (state == RUN) && !EX_MulDiv && load_use;
   assign Dbg_State = state;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= RUN;
         cnt   <= '0;
      end else if (redirect) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         case (state)
            RUN: begin
               if (EX_MulDiv) begin
                  state <= MD_BUSY;
                  cnt   <= CNT_W'(MULDIV_CYCLES - 2);
               end
            end
            MD_BUSY: begin
               if (cnt == '0) begin
                  state <= RUN;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= RUN;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      PC_Ld          = 1'b1;
      PCSrc_Redirect = 1'b0;
      IFID_Ld        = 1'b1;
      IFID_Clr       = 1'b0;
      IDEX_Ld        = 1'b1;
      IDEX_Clr       = 1'b0;
      EXMEM_Ld       = 1'b1;
      EXMEM_Clr      = 1'b0;
      MEMWB_Ld       = 1'b1;
      MEMWB_Clr      = 1'b0;
      MulDiv_Busy    = 1'b0;
      if (Rst) begin
         PC_Ld     = 1'b0;
         IFID_Ld   = 1'b0;
         IFID_Clr  = 1'b1;
         IDEX_Ld   = 1'b0;
         IDEX_Clr  = 1'b1;
         EXMEM_Ld  = 1'b0;
         EXMEM_Clr = 1'b1;
         MEMWB_Ld  = 1'b0;
         MEMWB_Clr = 1'b1;
      end else if (redirect) begin
         PCSrc_Redirect = 1'b1;
         IFID_Clr       = 1'b1;
         IDEX_Clr       = 1'b1;
         EXMEM_Clr      = 1'b1;
      end else if (md_hold) begin
         PC_Ld       = 1'b0;
         IFID_Ld     = 1'b0;
         IDEX_Ld     = 1'b0;
         EXMEM_Clr   = 1'b1;
         MulDiv_Busy = 1'b1;
      end else if (stall) begin
         PC_Ld    = 1'b0;
         IFID_Ld  = 1'b0;
         IDEX_Clr = 1'b1;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Stall_Cnt  <= '0;
         MulDiv_Cnt <= '0;
         Flush_Cnt  <= '0;
      end else begin
         if (stall && (Stall_Cnt != '1)) begin
            Stall_Cnt <= Stall_Cnt + 32'd1;
         end
         if (md_hold && (MulDiv_Cnt != '1)) begin
            MulDiv_Cnt <= MulDiv_Cnt + 32'd1;
         end
         if (redirect && (Flush_Cnt != '1)) begin
            Flush_Cnt <= Flush_Cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and random checks of pipeline_hazard_ctrl against an occupancy-count reference model.
module tb_pipeline_hazard_ctrl;

   import pipeline_pkg::*;

   localparam int W  = 5;
   localparam int MD = 4;

   logic         Clk = 1'b0;
   logic         Rst = 1'b1;
   logic [W-1:0] ID_Rs = '0;
   logic [W-1:0] ID_Rt = '0;
   logic         ID_UsesRs = 1'b0;
   logic         ID_UsesRt = 1'b0;
   logic         EX_MemRead = 1'b0;
   logic [W-1:0] EX_RegDstData = '0;
   logic         EX_MulDiv = 1'b0;
   logic         MEM_Branch = 1'b0;
   logic         MEM_Zero = 1'b0;
   logic [1:0]   MEM_Jump = 2'b00;
   logic         PC_Ld, PCSrc_Redirect, IFID_Ld, IFID_Clr, IDEX_Ld, IDEX_Clr;
   logic         EXMEM_Ld, EXMEM_Clr, MEMWB_Ld, MEMWB_Clr, MulDiv_Busy;
   state_t       Dbg_State;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0]  Stall_Cnt, MulDiv_Cnt, Flush_Cnt;
`endif

   int vectors = 0;
   int miscompares = 0;
   // Remaining mult/div occupancy cycles after the entry cycle, release cycle included.
   int md_left = 0;
   int n_stall = 0;
   int n_md = 0;
   int n_flush = 0;

   pipeline_hazard_ctrl #(.REG_W(W), .MULDIV_CYCLES(MD), .CNT_W(3)) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .ID_Rs          (ID_Rs),
      .ID_Rt          (ID_Rt),
      .ID_UsesRs      (ID_UsesRs),
      .ID_UsesRt      (ID_UsesRt),
      .EX_MemRead     (EX_MemRead),
      .EX_RegDstData  (EX_RegDstData),
      .EX_MulDiv      (EX_MulDiv),
      .MEM_Branch     (MEM_Branch),
      .MEM_Zero       (MEM_Zero),
      .MEM_Jump       (MEM_Jump),
      .PC_Ld          (PC_Ld),
      .PCSrc_Redirect (PCSrc_Redirect),
      .IFID_Ld        (IFID_Ld),
      .IFID_Clr       (IFID_Clr),
      .IDEX_Ld        (IDEX_Ld),
      .IDEX_Clr       (IDEX_Clr),
      .EXMEM_Ld       (EXMEM_Ld),
      .EXMEM_Clr      (EXMEM_Clr),
      .MEMWB_Ld       (MEMWB_Ld),
      .MEMWB_Clr      (MEMWB_Clr),
      .MulDiv_Busy    (MulDiv_Busy),
`ifdef PIPE_PERF_CNT_EN
      .Stall_Cnt      (Stall_Cnt),
      .MulDiv_Cnt     (MulDiv_Cnt),
      .Flush_Cnt      (Flush_Cnt),
`endif
      .Dbg_State      (Dbg_State)
   );

   always #5 Clk = ~Clk;

   function automatic logic m_redirect();
      return (MEM_Branch && MEM_Zero) || (MEM_Jump != 2'b00);
   endfunction

   function automatic logic m_load_use();
      logic hit;
      hit = (ID_UsesRs && ID_Rs == EX_RegDstData) || (ID_UsesRt && ID_Rt == EX_RegDstData);
      return EX_MemRead && (EX_RegDstData != 0) && hit;
   endfunction

   // A mult/div holds the front end on its entry cycle and on every cycle but the last.
   function automatic logic m_busy();
      return !m_redirect() && ((md_left > 1) || (md_left == 0 && EX_MulDiv));
   endfunction

   function automatic logic m_stall();
      return !m_redirect() && md_left == 0 && !EX_MulDiv && m_load_use();
   endfunction

   task automatic check_now(input string tag);
      logic pc, rd, ifl, ifc, idl, idc, exl, exc, mwl, mwc, bz;
      logic [10:0] exp_v, obs_v;
      state_t exp_st;
      {pc, rd, ifl, ifc, idl, idc, exl, exc, mwl, mwc, bz} = 11'b10101010100;
      if (Rst) begin
         md_left = 0;
         {pc, ifl, idl, exl, mwl} = 5'b00000;
         {ifc, idc, exc, mwc} = 4'b1111;
      end else if (m_redirect()) begin
         rd = 1'b1;
         {ifc, idc, exc} = 3'b111;
      end else if (m_busy()) begin
         {pc, ifl, idl} = 3'b000;
         exc = 1'b1;
         bz  = 1'b1;
      end else if (m_stall()) begin
         {pc, ifl} = 2'b00;
         idc = 1'b1;
      end
      exp_v = {pc, rd, ifl, ifc, idl, idc, exl, exc, mwl, mwc, bz};
      obs_v = {PC_Ld, PCSrc_Redirect, IFID_Ld, IFID_Clr, IDEX_Ld, IDEX_Clr,
               EXMEM_Ld, EXMEM_Clr, MEMWB_Ld, MEMWB_Clr, MulDiv_Busy};
      vectors++;
      assert (obs_v === exp_v) else begin
         miscompares++;
         $error("FAIL %s: {pc,redir,ifid_ld/clr,idex_ld/clr,exmem_ld/clr,memwb_ld/clr,busy} observed=%b expected=%b",
                tag, obs_v, exp_v);
      end
      exp_st = (!Rst && md_left > 0) ? MD_BUSY : RUN;
      vectors++;
      assert (Dbg_State === exp_st) else begin
         miscompares++;
         $error("FAIL %s_state: observed=%0d expected=%0d", tag, Dbg_State, exp_st);
      end
   endtask

   task automatic advance();
      if (Rst) begin
         md_left = 0;
         n_stall = 0;
         n_md    = 0;
         n_flush = 0;
      end else begin
         if (m_redirect()) n_flush++;
         if (m_busy())     n_md++;
         if (m_stall())    n_stall++;
         if (m_redirect())      md_left = 0;
         else if (md_left > 0)  md_left--;
         else if (EX_MulDiv)    md_left = MD - 1;
      end
   endtask

   task automatic run_cycle(input string tag);
      @(negedge Clk);
      check_now(tag);
      @(posedge Clk);
      advance();
      #1;
   endtask

   task automatic drive(input logic [W-1:0] rs, input logic [W-1:0] rt, input logic urs,
                        input logic urt, input logic mr, input logic [W-1:0] rdst,
                        input logic md, input logic br, input logic z, input logic [1:0] j);
      ID_Rs = rs; ID_Rt = rt; ID_UsesRs = urs; ID_UsesRt = urt;
      EX_MemRead = mr; EX_RegDstData = rdst; EX_MulDiv = md;
      MEM_Branch = br; MEM_Zero = z; MEM_Jump = j;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
   endtask

   initial begin
      run_cycle("rst_init");
      Rst = 1'b0;
      run_cycle("idle");

      // asynchronous reset asserted between clock edges
      #2 Rst = 1'b1;
      #1 check_now("rst_async");
      run_cycle("rst_hold");
      Rst = 1'b0;
      run_cycle("rst_release");

      drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 2'b00);
      run_cycle("lu_rs");
      idle();
      run_cycle("lu_after");
      drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00);
      run_cycle("lu_r0");
      drive(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 2'b00);
      run_cycle("lu_rt");
      drive(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 2'b00);
      run_cycle("lu_unused");

      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00);
      for (int i = 0; i < MD; i++) run_cycle($sformatf("md_occ%0d", i));
      idle();
      run_cycle("md_after");

      drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 2'b00);
      run_cycle("redir_over_lu");
      idle();
      run_cycle("redir_after");

      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00);
      run_cycle("abort_entry");
      run_cycle("abort_cnt2");
      MEM_Jump = 2'b10;
      run_cycle("abort_jump");
      idle();
      run_cycle("abort_after");

      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00);
      run_cycle("mdrst_entry");
      run_cycle("mdrst_busy");
      #2 Rst = 1'b1;
      #1 check_now("mdrst_async");
      run_cycle("mdrst_hold");
      Rst = 1'b0;
      idle();
      run_cycle("mdrst_after");

      for (int i = 0; i < 600; i++) begin
         Rst = ($urandom_range(0, 149) == 0);
         drive(W'($urandom_range(0, 3)), W'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), W'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
         run_cycle("random");
      end
      Rst = 1'b0;
      idle();
      run_cycle("final_idle");

`ifdef PIPE_PERF_CNT_EN
      @(negedge Clk);
      vectors++;
      assert (Stall_Cnt === 32'(n_stall)) else begin
         miscompares++;
         $error("FAIL stall_cnt: observed=%0d expected=%0d", Stall_Cnt, n_stall);
      end
      vectors++;
      assert (MulDiv_Cnt === 32'(n_md)) else begin
         miscompares++;
         $error("FAIL muldiv_cnt: observed=%0d expected=%0d", MulDiv_Cnt, n_md);
      end
      vectors++;
      assert (Flush_Cnt === 32'(n_flush)) else begin
         miscompares++;
         $error("FAIL flush_cnt: observed=%0d expected=%0d", Flush_Cnt, n_flush);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
